// File: rtl/dds_pkg.sv
// Shared definitions for the DDS waveform generator: waveform mode codes,
// sweep FSM states, quadrant bit positions and the quarter-sine ROM builder.
package dds_pkg;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_SQUARE = 2'd1,
    MODE_SAW    = 2'd2,
    MODE_TRI    = 2'd3
  } mode_t;

  typedef enum logic {
    SWEEP_IDLE = 1'b0,
    SWEEP_RUN  = 1'b1
  } sweep_state_t;

  // Within the top two lookup-phase bits: bit 1 selects the negative half,
  // bit 0 selects the mirrored (falling) quarter.
  localparam int QUAD_HALF_BIT   = 1;
  localparam int QUAD_MIRROR_BIT = 0;

  // pi scaled by 2^30 for the fixed-point sine evaluation below.
  localparam longint PI_FIX = 64'sd3373259426;

  // Entry i of the quarter-wave table: round((2^(out_w-1)-1) * sin(pi/2*(i+0.5)/Q)).
  // Evaluated at elaboration with an integer Taylor series (2^30 fixed point)
  // so the ROM contents need no real-number support from the tools.
  function automatic int quarter_sine(input int i, input int addr_w, input int out_w);
    longint q_entries;
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint amp;
    q_entries = longint'(1) << (addr_w - 2);
    x         = (PI_FIX * longint'(2 * i + 1)) / (4 * q_entries);
    x2        = (x * x) >>> 30;
    term      = x;
    sum       = x;
    for (int k = 1; k <= 8; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    amp = (longint'(1) << (out_w - 1)) - 1;
    return int'((amp * sum + (longint'(1) << 29)) >>> 30);
  endfunction

endpackage

// File: rtl/dds_if.sv
// Frequency-word handshake and sample output bundle of the DDS core.
// master = the block feeding frequency words and consuming samples,
// slave  = the DDS core itself.
interface dds_if #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 8
);
  logic             fcw_valid;
  logic             fcw_ready;
  logic [ACC_W-1:0] fcw_data;
  logic [OUT_W-1:0] wave_out;
  logic             out_valid;
  logic             wrap;

  modport master (
    output fcw_valid, fcw_data,
    input  fcw_ready, wave_out, out_valid, wrap
  );

  modport slave (
    input  fcw_valid, fcw_data,
    output fcw_ready, wave_out, out_valid, wrap
  );
endinterface

// File: rtl/dds_quarter_sine_rom.sv
// Combinational quarter-wave sine table: index -> magnitude q (OUT_W-1 bits).
// Contents are computed at elaboration from dds_pkg::quarter_sine.
module dds_quarter_sine_rom
  import dds_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int OUT_W  = 8
) (
  input  logic [ADDR_W-3:0] index,
  output logic [OUT_W-2:0]  q
);

  localparam int Q = 2 ** (ADDR_W - 2);

  logic [OUT_W-2:0] rom_q [Q];

  for (genvar i = 0; i < Q; i++) begin : g_rom
    localparam int QV = quarter_sine(i, ADDR_W, OUT_W);
    assign rom_q[i] = QV[OUT_W-2:0];
  end

  assign q = rom_q[index];

endmodule

// File: rtl/dds_waveform_gen.sv
// Multi-waveform DDS core: phase accumulator, phase offset, quarter-wave sine
// ROM and sine/square/saw/triangle shaping, with a two-stage lookup pipeline.
// Optional feature: define DDS_SWEEP_EN to build the linear FCW sweep FSM;
// without it the sweep inputs are ignored and sweep_busy stays 0.
module dds_waveform_gen
  import dds_pkg::*;
#(
  parameter int ACC_W  = 24,
  parameter int ADDR_W = 8,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  dds_if.slave              bus,
  input  logic              en,
  input  logic [ADDR_W-1:0] phase_off,
  input  logic [1:0]        mode,
  input  logic              sync,
  input  logic              sweep_go,
  input  logic [ACC_W-1:0]  sweep_step,
  input  logic [ACC_W-1:0]  sweep_stop,
  output logic              sweep_busy
);

  localparam int MSB = ADDR_W - 1;

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  fcw;
  logic [ACC_W:0]    acc_sum;
  logic              carry_s0;
  logic [ADDR_W-1:0] phase_q;
  mode_t             mode_q;
  logic              carry_s1;
  logic              live_s1;

  assign acc_sum       = {1'b0, acc} + {1'b0, fcw};
  assign bus.fcw_ready = !sweep_busy;

`ifdef DDS_SWEEP_EN
  sweep_state_t   state;
  logic [ACC_W:0] sweep_sum;

  assign sweep_sum = {1'b0, fcw} + {1'b0, sweep_step};

  // Frequency word register plus sweep FSM: loads only while idle, ramps fcw
  // each enabled cycle while sweeping and lands exactly on sweep_stop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= SWEEP_IDLE;
      fcw        <= ACC_W'(1);
      sweep_busy <= 1'b0;
    end else begin
      case (state)
        SWEEP_IDLE: begin
          if (bus.fcw_valid && bus.fcw_ready) begin
            fcw <= bus.fcw_data;
          end
          if (sweep_go) begin
            state      <= SWEEP_RUN;
            sweep_busy <= 1'b1;
          end
        end
        SWEEP_RUN: begin
          if (en) begin
            if (sweep_sum[ACC_W] || (sweep_sum[ACC_W-1:0] >= sweep_stop)) begin
              fcw        <= sweep_stop;
              state      <= SWEEP_IDLE;
              sweep_busy <= 1'b0;
            end else begin
              fcw <= sweep_sum[ACC_W-1:0];
            end
          end
        end
        default: begin
          state      <= SWEEP_IDLE;
          sweep_busy <= 1'b0;
        end
      endcase
    end
  end
`else
  logic unused_sweep;

  assign unused_sweep = ^{sweep_go, sweep_step, sweep_stop};
  assign sweep_busy   = 1'b0;

  // Frequency word register: takes a new word on every accepted handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcw <= ACC_W'(1);
    end else if (bus.fcw_valid && bus.fcw_ready) begin
      fcw <= bus.fcw_data;
    end
  end
`endif

  // Stage 0: phase accumulator; sync overrides en, and the carry-out is kept
  // so the wrap flag can travel alongside the phase it produced.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      carry_s0 <= 1'b0;
    end else if (sync) begin
      acc      <= '0;
      carry_s0 <= 1'b0;
    end else if (en) begin
      acc      <= acc_sum[ACC_W-1:0];
      carry_s0 <= acc_sum[ACC_W];
    end
  end

  // Stage 1: offset lookup phase and capture mode; live_s1 marks that this
  // stage was loaded by the most recent clock (cleared by any frozen cycle).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q  <= '0;
      mode_q   <= MODE_SINE;
      carry_s1 <= 1'b0;
      live_s1  <= 1'b0;
    end else if (en) begin
      phase_q  <= acc[ACC_W-1 -: ADDR_W] + phase_off;
      mode_q   <= mode_t'(mode);
      carry_s1 <= carry_s0;
      live_s1  <= 1'b1;
    end else begin
      live_s1  <= 1'b0;
    end
  end

  logic [1:0]              quadrant;
  logic [ADDR_W-3:0]       rom_index;
  logic [OUT_W-2:0]        rom_q;
  logic [OUT_W-1:0]        sine_val;
  logic [OUT_W-1:0]        square_val;
  logic [ADDR_W+OUT_W-1:0] saw_wide;
  logic [ADDR_W-2:0]       tri_t;
  logic [ADDR_W+OUT_W-2:0] tri_wide;
  logic [OUT_W-1:0]        sample;

  assign quadrant  = phase_q[MSB -: 2];
  assign rom_index = quadrant[QUAD_MIRROR_BIT] ? ~phase_q[ADDR_W-3:0] : phase_q[ADDR_W-3:0];

  dds_quarter_sine_rom #(
    .ADDR_W (ADDR_W),
    .OUT_W  (OUT_W)
  ) u_rom (
    .index (rom_index),
    .q     (rom_q)
  );

  // Negative half uses 2^(OUT_W-1)-1-q, which is simply the complement of q.
  assign sine_val   = quadrant[QUAD_HALF_BIT] ? {1'b0, ~rom_q} : {1'b1, rom_q};
  assign square_val = phase_q[MSB] ? '0 : '1;
  assign saw_wide   = {phase_q, {OUT_W{1'b0}}};
  assign tri_t      = phase_q[MSB] ? ~phase_q[ADDR_W-2:0] : phase_q[ADDR_W-2:0];
  // Falling half fills the widened LSBs with ones so it mirrors the rising
  // half exactly (0,2,..,254 up then 255,253,..,1 down at 8/8 bits).
  assign tri_wide   = {tri_t, {OUT_W{phase_q[MSB]}}};

  // Waveform shaping mux for the stage-2 sample.
  always_comb begin
    sample = sine_val;
    case (mode_q)
      MODE_SINE:   sample = sine_val;
      MODE_SQUARE: sample = square_val;
      MODE_SAW:    sample = saw_wide[ADDR_W+OUT_W-1 -: OUT_W];
      MODE_TRI:    sample = tri_wide[ADDR_W+OUT_W-2 -: OUT_W];
      default:     sample = sine_val;
    endcase
  end

  // Stage 2: registered sample; valid only after two consecutive enabled
  // cycles, and wrap is suppressed whenever the sample is not valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.wave_out  <= '0;
      bus.out_valid <= 1'b0;
      bus.wrap      <= 1'b0;
    end else if (en) begin
      bus.wave_out  <= sample;
      bus.out_valid <= live_s1;
      bus.wrap      <= carry_s1 & live_s1;
    end else begin
      bus.out_valid <= 1'b0;
      bus.wrap      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dds_waveform_gen.sv
// Scoreboard testbench for dds_waveform_gen (ACC_W=24, ADDR_W=8, OUT_W=8).
// Sweep checks follow DDS_SWEEP_EN when the bench is built with it defined.
module tb_dds_waveform_gen;

  localparam int  ACC_W  = 24;
  localparam int  ADDR_W = 8;
  localparam int  OUT_W  = 8;
  localparam int  PHASES = 2 ** ADDR_W;
  localparam real PI     = 3.14159265358979323846;
`ifdef DDS_SWEEP_EN
  localparam int  EXP_SWEEP_CYCLES = 16;
`else
  localparam int  EXP_SWEEP_CYCLES = 0;
`endif

  typedef struct {
    int sample;
    bit wrap;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [ADDR_W-1:0] phase_off;
  logic [1:0]        mode;
  logic              sync;
  logic              sweep_go;
  logic [ACC_W-1:0]  sweep_step;
  logic [ACC_W-1:0]  sweep_stop;
  logic              sweep_busy;

  dds_if #(.ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  dds_waveform_gen #(
    .ACC_W  (ACC_W),
    .ADDR_W (ADDR_W),
    .OUT_W  (OUT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .en         (en),
    .phase_off  (phase_off),
    .mode       (mode),
    .sync       (sync),
    .sweep_go   (sweep_go),
    .sweep_step (sweep_step),
    .sweep_stop (sweep_stop),
    .sweep_busy (sweep_busy)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  longint m_acc;
  longint m_fcw;
  bit     m_busy;
  bit     m_carry;
  int     m_pend_sample;
  bit     m_pend_wrap;
  bit     m_pend_ok;
  bit     exp_valid;
  bit     exp_hold;
  bit     exp_reset;
  bit     exp_busy;

  // Reference waveform value for lookup phase ph (0..PHASES-1) in mode md.
  function automatic int ref_sample(input int ph, input int md);
    real x;
    int  r;
    case (md)
      0: begin
        x = (2.0 ** (OUT_W - 1) - 1.0) * $sin(2.0 * PI * (real'(ph) + 0.5) / real'(PHASES));
        r = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
        return (ph < PHASES / 2) ? (2 ** (OUT_W - 1)) + r : (2 ** (OUT_W - 1)) - 1 + r;
      end
      1: return (ph < PHASES / 2) ? (2 ** OUT_W) - 1 : 0;
      2: return ph;
      default: return (ph < PHASES / 2) ? 2 * ph : 2 * (PHASES - 1 - ph) + 1;
    endcase
  endfunction

  task automatic check_output(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: advances on every clock from the inputs seen at the
  // edge and queues the sample the DUT must present one enabled clock later.
  always @(posedge clk) begin
    longint nxt;
    longint old_fcw;
    bit     old_busy;
    int     ph;
    exp_reset = 1'b0;
    exp_hold  = 1'b0;
    if (!rst_n) begin
      m_acc     = 0;
      m_fcw     = 1;
      m_busy    = 1'b0;
      m_carry   = 1'b0;
      m_pend_ok = 1'b0;
      exp_valid = 1'b0;
      exp_reset = 1'b1;
    end else begin
      old_fcw   = m_fcw;
      old_busy  = m_busy;
      exp_valid = en && m_pend_ok;
      if (en) begin
        if (m_pend_ok) sb_q.push_back('{sample: m_pend_sample, wrap: m_pend_wrap});
        ph            = int'(((m_acc >> (ACC_W - ADDR_W)) + longint'(phase_off)) % PHASES);
        m_pend_sample = ref_sample(ph, int'(mode));
        m_pend_wrap   = m_carry;
        m_pend_ok     = 1'b1;
      end else begin
        m_pend_ok = 1'b0;
        exp_hold  = 1'b1;
      end
      if (sync) begin
        m_acc   = 0;
        m_carry = 1'b0;
      end else if (en) begin
        nxt     = m_acc + old_fcw;
        m_carry = (nxt >= (longint'(1) << ACC_W));
        m_acc   = nxt % (longint'(1) << ACC_W);
      end
      if (!old_busy) begin
        if (bus.fcw_valid) m_fcw = longint'(bus.fcw_data);
`ifdef DDS_SWEEP_EN
        if (sweep_go) m_busy = 1'b1;
`endif
      end else if (en) begin
        nxt = m_fcw + longint'(sweep_step);
        if (nxt >= longint'(sweep_stop)) begin
          m_fcw  = longint'(sweep_stop);
          m_busy = 1'b0;
        end else begin
          m_fcw = nxt;
        end
      end
    end
    exp_busy = m_busy;
  end

  // Monitor: compares DUT outputs shortly after each edge against the queue.
  initial begin
    logic [OUT_W-1:0] prev_wave;
    exp_t             e;
    prev_wave = '0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_reset) begin
        check_output("reset_wave", bus.wave_out, 0);
        check_output("reset_valid", bus.out_valid, 0);
        check_output("reset_wrap", bus.wrap, 0);
        check_output("reset_ready", bus.fcw_ready, 1);
        check_output("reset_busy", sweep_busy, 0);
      end else begin
        check_output("out_valid", bus.out_valid, exp_valid);
        check_output("sweep_busy", sweep_busy, exp_busy);
        check_output("fcw_ready", bus.fcw_ready, !exp_busy);
        if (exp_valid) begin
          if (sb_q.size() == 0) begin
            check_output("sb_underflow", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check_output("wave_out", bus.wave_out, e.sample);
            check_output("wrap", bus.wrap, e.wrap);
          end
        end else begin
          check_output("wrap_idle", bus.wrap, 0);
          if (exp_hold) check_output("wave_hold", bus.wave_out, prev_wave);
        end
      end
      prev_wave = bus.wave_out;
    end
  end

  task automatic apply_stimulus(input bit e, input logic [1:0] md, input logic [ADDR_W-1:0] off,
                                input bit sy, input int cycles);
    en        = e;
    mode      = md;
    phase_off = off;
    sync      = sy;
    @(negedge clk);
    sync = 1'b0;
    for (int i = 1; i < cycles; i++) @(negedge clk);
  endtask

  task automatic load_fcw(input logic [ACC_W-1:0] value);
    bus.fcw_valid = 1'b1;
    bus.fcw_data  = value;
    for (int i = 0; i < 64; i++) begin
      if (bus.fcw_ready) begin
        @(negedge clk);
        bus.fcw_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    bus.fcw_valid = 1'b0;
    check_output("load_timeout", 1, 0);
  endtask

  task automatic measure_sweep(output int cnt);
    sweep_go = 1'b1;
    @(negedge clk);
    sweep_go = 1'b0;
    cnt = 0;
    while (sweep_busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    rst_n         = 1'b0;
    en            = 1'b0;
    phase_off     = '0;
    mode          = 2'd0;
    sync          = 1'b0;
    sweep_go      = 1'b0;
    sweep_step    = '0;
    sweep_stop    = '0;
    bus.fcw_valid = 1'b0;
    bus.fcw_data  = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] default fcw, sine");
    apply_stimulus(1'b1, 2'd0, 8'd0, 1'b0, 12);

    $display("[TB] fcw 0x010000, all modes");
    load_fcw(24'h010000);
    apply_stimulus(1'b1, 2'd0, 8'd0, 1'b1, 600);
    for (int m = 1; m < 4; m++) apply_stimulus(1'b1, 2'(m), 8'd0, 1'b1, 300);

    $display("[TB] phase offset and sync");
    apply_stimulus(1'b1, 2'd0, 8'd64, 1'b1, 300);
    apply_stimulus(1'b1, 2'd0, 8'd0, 1'b1, 50);

    $display("[TB] enable gap");
    apply_stimulus(1'b1, 2'd3, 8'd0, 1'b0, 20);
    apply_stimulus(1'b0, 2'd3, 8'd0, 1'b0, 5);
    apply_stimulus(1'b1, 2'd3, 8'd0, 1'b0, 30);

    $display("[TB] fcw zero and aliased fcw");
    load_fcw(24'h000000);
    apply_stimulus(1'b1, 2'd2, 8'd17, 1'b0, 20);
    load_fcw(24'hF00000);
    apply_stimulus(1'b1, 2'd0, 8'd0, 1'b0, 50);

    $display("[TB] sweep");
    load_fcw(24'h001000);
    sweep_step = 24'h000100;
    sweep_stop = 24'h002000;
    measure_sweep(cnt);
    check_output("sweep_length", cnt, EXP_SWEEP_CYCLES);
    apply_stimulus(1'b1, 2'd2, 8'd0, 1'b0, 30);
    sweep_go = 1'b1;
    bus.fcw_valid = 1'b1;
    bus.fcw_data  = 24'h123456;
    @(negedge clk);
    sweep_go = 1'b0;
    repeat (5) @(negedge clk);
    bus.fcw_valid = 1'b0;
    repeat (20) @(negedge clk);
    load_fcw(24'h001000);
    sweep_go = 1'b1;
    @(negedge clk);
    sweep_go = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus(1'b1, 2'd2, 8'd0, 1'b0, 60);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 1500; c++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) phase_off = 8'($urandom_range(0, 255));
      sync          = ($urandom_range(0, 63) == 0);
      bus.fcw_valid = ($urandom_range(0, 39) == 0);
      bus.fcw_data  = ($urandom_range(0, 7) == 0) ? 24'($urandom) : 24'($urandom_range(0, 1 << 18));
      sweep_go      = ($urandom_range(0, 99) == 0);
      sweep_step    = 24'($urandom_range(1, 4096));
      sweep_stop    = 24'($urandom_range(0, 1 << 20));
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
    sync          = 1'b0;
    sweep_go      = 1'b0;
    bus.fcw_valid = 1'b0;
    apply_stimulus(1'b1, 2'd1, 8'd0, 1'b0, 10);
    check_output("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
